au_issue_stage: RTL and testbench

// Operand issue and result capture stage around the 5-bit arithmetic unit (AU: A, B, chave -> resultado, igual, diferente).

---
 rtl/au_issue_stage.sv | 177 +++++++++++++++++
 tb/tb_au_issue_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_issue_stage.sv
// Operand issue / result capture stage for the 5-bit AU: request FIFO, operand
// registers held across a fixed settle time, and a valid/ready result register.
module au_issue_stage #(
    parameter int WIDTH      = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int SETTLE     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_chave,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic             au_chave,
    input  logic [WIDTH-1:0] au_resultado,
    input  logic             au_igual,
    input  logic             au_diferente,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_resultado,
    output logic             out_igual,
    output logic             out_diferente,
    output logic             out_chave,
    output logic             busy,
    output logic [7:0]       op_count
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int EW   = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [EW-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CNTW-1:0] count_r;
    logic [SW-1:0]   settle_r;
    logic            push_s;
    logic            pop_s;
    logic            capture_s;
    logic            xfer_s;
    logic            fifo_empty_s;

    // in_ready depends only on registered count, so a full FIFO rejects a push even when popping
    assign in_ready     = (count_r != CNTW'(FIFO_DEPTH));
    assign fifo_empty_s = (count_r == CNTW'(0));
    assign push_s       = in_valid & in_ready;
    assign busy         = (state_r != IDLE) | ~fifo_empty_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-edge control strobes
    always_comb begin
        state_s   = state_r;
        pop_s     = 1'b0;
        capture_s = 1'b0;
        xfer_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (settle_r == SW'(1)) begin
                    capture_s = 1'b1;
                    state_s   = OUT;
                end else begin
                    state_s = ISSUE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    xfer_s = 1'b1;
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        state_s = ISSUE;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {in_a, in_b, in_chave};
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNTW'(1);
                2'b01:   count_r <= count_r - CNTW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Operand issue registers and settle countdown; operands move only on a pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            au_a     <= '0;
            au_b     <= '0;
            au_chave <= 1'b0;
            settle_r <= '0;
        end else begin
            if (pop_s) begin
                {au_a, au_b, au_chave} <= fifo_mem_r[rd_ptr_r];
                settle_r               <= SW'(SETTLE);
            end else if (state_r == ISSUE) begin
                settle_r <= settle_r - SW'(1);
            end
        end
    end

    // Result capture, output handshake and completion counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_resultado <= '0;
            out_igual     <= 1'b0;
            out_diferente <= 1'b0;
            out_chave     <= 1'b0;
            op_count      <= 8'd0;
        end else begin
            if (capture_s) begin
                out_resultado <= au_resultado;
                out_igual     <= au_igual;
                out_diferente <= au_diferente;
                out_chave     <= au_chave;
                out_valid     <= 1'b1;
            end else if (xfer_s) begin
                out_valid <= 1'b0;
                op_count  <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_au_issue_stage.sv
// Bench for au_issue_stage: directed vector table, backpressure/reset sequences,
// and randomized traffic scored against a queue-based reference model.
module tb_au_issue_stage;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_a;
    logic [4:0] in_b;
    logic       in_chave;
    logic [4:0] au_a;
    logic [4:0] au_b;
    logic       au_chave;
    logic [4:0] au_resultado;
    logic       au_igual;
    logic       au_diferente;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_resultado;
    logic       out_igual;
    logic       out_diferente;
    logic       out_chave;
    logic       busy;
    logic [7:0] op_count;

    au_issue_stage #(.WIDTH(5), .FIFO_DEPTH(2), .SETTLE(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_chave(in_chave),
        .au_a(au_a), .au_b(au_b), .au_chave(au_chave),
        .au_resultado(au_resultado), .au_igual(au_igual), .au_diferente(au_diferente),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_resultado(out_resultado), .out_igual(out_igual),
        .out_diferente(out_diferente), .out_chave(out_chave),
        .busy(busy), .op_count(op_count)
    );

    // Arithmetic unit model
    assign au_resultado = au_chave ? (au_a - au_b) : (au_a + au_b);
    assign au_igual     = (au_a == au_b);
    assign au_diferente = (au_a != au_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic       ch;
    } req_t;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic       ch;
        logic [4:0] res;
        logic       ig;
        logic       dif;
    } vec_t;

    req_t q[$];
    vec_t vecs[6];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_xfer = 0;
    int   cyc    = 0;
    bit   last_push;
    bit   last_xfer;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: score the handshakes seen before the edge, then advance to edge+1
    task automatic tick();
        req_t e;
        int   er;
        last_push = 1'b0;
        last_xfer = 1'b0;
        if (in_valid && in_ready) begin
            e.a = in_a; e.b = in_b; e.ch = in_chave;
            q.push_back(e);
            last_push = 1'b1;
        end
        if (out_valid && out_ready) begin
            last_xfer = 1'b1;
            if (q.size() == 0) begin
                chk("spurious_output", 1, 0);
            end else begin
                e  = q.pop_front();
                er = e.ch ? (int'(e.a) - int'(e.b) + 32) % 32 : (int'(e.a) + int'(e.b)) % 32;
                chk("resultado", int'(out_resultado), er);
                chk("igual", int'(out_igual), (e.a == e.b) ? 1 : 0);
                chk("diferente", int'(out_diferente), (e.a != e.b) ? 1 : 0);
                chk("out_chave", int'(out_chave), int'(e.ch));
            end
            n_xfer++;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("op_count", int'(op_count), n_xfer % 256);
    endtask

    task automatic push_req(input logic [4:0] a, input logic [4:0] b, input logic ch);
        bit ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_chave = ch; in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            ok = last_push;
        end
        in_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (q.size() != 0 || busy || out_valid); i++) tick();
        chk(name, q.size(), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        n_xfer = 0;
    endtask

    initial begin
        logic [4:0] held_a;
        logic [4:0] held_r;
        int         pushes;
        int         prev;
        int         bad;

        vecs[0] = '{a: 5'd21, b: 5'd14, ch: 1'b0, res: 5'd3,  ig: 1'b0, dif: 1'b1};
        vecs[1] = '{a: 5'd15, b: 5'd15, ch: 1'b1, res: 5'd0,  ig: 1'b1, dif: 1'b0};
        vecs[2] = '{a: 5'd31, b: 5'd1,  ch: 1'b0, res: 5'd0,  ig: 1'b0, dif: 1'b1};
        vecs[3] = '{a: 5'd3,  b: 5'd5,  ch: 1'b1, res: 5'd30, ig: 1'b0, dif: 1'b1};
        vecs[4] = '{a: 5'd0,  b: 5'd0,  ch: 1'b0, res: 5'd0,  ig: 1'b1, dif: 1'b0};
        vecs[5] = '{a: 5'd10, b: 5'd3,  ch: 1'b1, res: 5'd7,  ig: 1'b0, dif: 1'b1};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 5'd0; in_b = 5'd0; in_chave = 1'b0;
        #2;
        do_reset();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_op_count", int'(op_count), 0);
        chk("rst_au_a", int'(au_a), 0);
        chk("rst_out_resultado", int'(out_resultado), 0);

        // Directed vectors: exact latency and values
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            in_a = vecs[v].a; in_b = vecs[v].b; in_chave = vecs[v].ch; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("lat_t0_valid", int'(out_valid), 0);
            chk("lat_t0_busy", int'(busy), 1);
            tick();
            chk("lat_t1_valid", int'(out_valid), 0);
            chk("issue_au_a", int'(au_a), int'(vecs[v].a));
            tick();
            chk("lat_t2_valid", int'(out_valid), 1);
            chk("vec_resultado", int'(out_resultado), int'(vecs[v].res));
            chk("vec_igual", int'(out_igual), int'(vecs[v].ig));
            chk("vec_diferente", int'(out_diferente), int'(vecs[v].dif));
            chk("vec_chave", int'(out_chave), int'(vecs[v].ch));
            tick();
            chk("vec_done_valid", int'(out_valid), 0);
            chk("vec_done_busy", int'(busy), 0);
        end
        chk("vec_op_count", int'(op_count), 6);

        // Backpressure: output and FIFO fill, further push held off
        out_ready = 1'b0;
        push_req(5'd7, 5'd9, 1'b0);
        push_req(5'd20, 5'd4, 1'b1);
        push_req(5'd31, 5'd31, 1'b1);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_au_a", int'(au_a), 7);
        chk("bp_out_resultado", int'(out_resultado), 16);
        held_a = au_a;
        held_r = out_resultado;
        in_a = 5'd2; in_b = 5'd3; in_chave = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_held_off", int'(last_push), 0);
            chk("bp_au_stable", int'(au_a), int'(held_a));
            chk("bp_out_stable", int'(out_resultado), int'(held_r));
        end
        // Release with FIFO full and in_valid high: the pop edge must not push
        out_ready = 1'b1;
        tick();
        chk("full_pop_no_push", int'(last_push), 0);
        chk("full_pop_xfer", int'(last_xfer), 1);
        for (int i = 0; i < 20 && !last_push; i++) tick();
        chk("bp_late_push", int'(last_push), 1);
        drain("bp_drain");
        chk("bp_op_count", int'(op_count), 10);

        // Asynchronous reset while in ISSUE
        out_ready = 1'b1;
        push_req(5'd9, 5'd4, 1'b0);
        tick();
        chk("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_op_count", int'(op_count), 0);
        chk("arst_busy", int'(busy), 0);
        #1;
        reset = 1'b0;
        q.delete();
        n_xfer = 0;
        push_req(5'd6, 5'd6, 1'b1);
        drain("post_rst_drain");
        chk("post_rst_op_count", int'(op_count), 1);

        // 256 back-to-back ops: wrap and throughput
        do_reset();
        out_ready = 1'b1;
        pushes = 0; prev = -1; bad = 0;
        in_a = 5'($urandom); in_b = 5'($urandom); in_chave = 1'($urandom); in_valid = 1'b1;
        for (int i = 0; i < 2000 && n_xfer < 256; i++) begin
            tick();
            if (last_push) begin
                pushes++;
                if (pushes == 256) in_valid = 1'b0;
                else begin
                    in_a = 5'($urandom); in_b = 5'($urandom); in_chave = 1'($urandom);
                end
            end
            if (last_xfer) begin
                if (prev >= 0 && cyc - prev != 2) bad++;
                prev = cyc;
            end
        end
        chk("b2b_transfers", n_xfer, 256);
        chk("b2b_throughput_gaps", bad, 0);
        chk("b2b_op_count_wrap", int'(op_count), 0);
        drain("b2b_drain");

        // Randomized valid/ready traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a = 5'($urandom); in_b = 5'($urandom); in_chave = 1'($urandom);
            tick();
        end
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
